// File: rtl/tone_pkg.sv
// Shared definitions for the tone measurement block and its tonegen companion:
// divider overhead constant, FSM state encoding and the divider type.
package tone_pkg;

    // A tonegen half-period lasts divider + TONEGEN_OVERHEAD clk cycles.
    localparam int TONEGEN_OVERHEAD = 2;

    // Default width of a divider value.
    localparam int DIV_W = 32;

    typedef logic [DIV_W-1:0] divider_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

endpackage

// File: rtl/tone_meter_if.sv
// CPU-side read port of the tone meter: pulse-read data register plus status.
// master = CPU/bus side, slave = tone_meter.
interface tone_meter_if #(
    parameter int CNT_W = 32
);
    logic             rd_re;
    logic [CNT_W-1:0] rd_do;
    logic             rd_valid;
    logic             silent;

    modport master (
        output rd_re,
        input  rd_do,
        input  rd_valid,
        input  silent
    );

    modport slave (
        input  rd_re,
        output rd_do,
        output rd_valid,
        output silent
    );
endinterface

// File: rtl/tone_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin followed by a one-flop
// history register; reports the synchronised level and a one-cycle pulse on
// every rising or falling edge.
module tone_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the raw pin.
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) sync_reg[0] <= 1'b0;
                    else         sync_reg[0] <= din;
                end
            end else begin : g_next
                // Later stages resolve metastability of the previous stage.
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) sync_reg[gi] <= 1'b0;
                    else         sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign level = sync_reg[SYNC_STAGES-1];

    // History of the synchronised level for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) hist_reg <= 1'b0;
        else         hist_reg <= level;
    end

    assign edge_pulse = level ^ hist_reg;

endmodule

// File: rtl/tone_meter.sv
// tone_meter: measures the half-period of a square wave on tone_in and reports
// it as a tonegen divider (half-period - 2), 0 meaning silence.
// Optional build macro TONE_METER_AVG_EN: average the current and previous
// half-period so duty-cycle asymmetry cancels out.
module tone_meter
    import tone_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 16000000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         tone_in,
    tone_meter_if.slave  bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    // Half-periods need one extra bit (cnt+1), the average sum one more.
    localparam int               H_W       = CNT_W + 2;
    localparam logic [H_W-1:0]   OVH       = H_W'(TONEGEN_OVERHEAD);

    logic             level_unused;
    logic             edge_pulse;

    logic [CNT_W-1:0] cnt_reg;
    state_t           state_reg,    state_next;
    logic [CNT_W-1:0] rd_do_reg,    rd_do_next;
    logic             rd_valid_reg, rd_valid_next;
    logic             silent_reg,   silent_next;

    logic [H_W-1:0]   h_cur;
    logic [H_W-1:0]   h_eff;
    logic [CNT_W-1:0] d_val;
    logic             timeout;

    tone_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk),
        .resetn     (resetn),
        .din        (tone_in),
        .level      (level_unused),
        .edge_pulse (edge_pulse)
    );

    // Interval counter: restarts on each edge, saturates at the timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                  cnt_reg <= '0;
        else if (edge_pulse)          cnt_reg <= '0;
        else if (cnt_reg != TIMEOUT_C) cnt_reg <= cnt_reg + 1'b1;
    end

    assign timeout = (cnt_reg == TIMEOUT_C);
    // The edge cycle itself belongs to the interval, hence +1.
    assign h_cur   = H_W'(cnt_reg) + H_W'(1);

`ifdef TONE_METER_AVG_EN
    logic [H_W-1:0] hp_reg, hp_next;

    // The first sample after arming has no previous half-period to average.
    assign h_eff = (state_reg == MEASURE) ? ((h_cur + hp_reg) >> 1) : h_cur;

    // Previous half-period, cleared whenever the input goes silent.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) hp_reg <= '0;
        else         hp_reg <= hp_next;
    end
`else
    assign h_eff = h_cur;
`endif

    // Divider = half-period minus tonegen overhead, floored at zero.
    assign d_val = (h_eff < OVH) ? '0 : CNT_W'(h_eff - OVH);

    // State and read-register updates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            rd_do_reg    <= '0;
            rd_valid_reg <= 1'b0;
            silent_reg   <= 1'b1;
        end else begin
            state_reg    <= state_next;
            rd_do_reg    <= rd_do_next;
            rd_valid_reg <= rd_valid_next;
            silent_reg   <= silent_next;
        end
    end

    // Next-state logic; a written sample overrides a coincident read.
    always_comb begin
        state_next    = state_reg;
        rd_do_next    = rd_do_reg;
        rd_valid_next = rd_valid_reg & ~bus.rd_re;
        silent_next   = silent_reg;
`ifdef TONE_METER_AVG_EN
        hp_next       = hp_reg;
`endif
        case (state_reg)
            IDLE: begin
                // First edge only arms: its interval start is unknown.
                if (edge_pulse) state_next = ARMED;
            end
            ARMED: begin
                if (edge_pulse) begin
                    state_next    = MEASURE;
                    rd_do_next    = d_val;
                    rd_valid_next = 1'b1;
                    silent_next   = 1'b0;
`ifdef TONE_METER_AVG_EN
                    hp_next       = h_cur;
`endif
                end else if (timeout) begin
                    // Nothing was reported yet, so the data register is left alone.
                    state_next  = IDLE;
                    silent_next = 1'b1;
`ifdef TONE_METER_AVG_EN
                    hp_next     = '0;
`endif
                end
            end
            MEASURE: begin
                if (edge_pulse) begin
                    rd_do_next    = d_val;
                    rd_valid_next = 1'b1;
`ifdef TONE_METER_AVG_EN
                    hp_next       = h_cur;
`endif
                end else if (timeout) begin
                    // Silence is reported once as a zero sample.
                    state_next    = IDLE;
                    rd_do_next    = '0;
                    rd_valid_next = 1'b1;
                    silent_next   = 1'b1;
`ifdef TONE_METER_AVG_EN
                    hp_next       = '0;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.rd_do    = rd_do_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.silent   = silent_reg;

endmodule

// File: tb/tb_tone_meter.sv
// Bench for tone_meter: a tone generator drives the pin, a reference model
// pushes expected samples to a queue, a monitor pops them when rd_valid rises.
module tb_tone_meter;

    localparam int TIMEOUT = 1000;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
    } exp_t;

    logic clk;
    logic resetn;
    logic tone_in;

    tone_meter_if #(.CNT_W(32)) bus_if ();

    tone_meter #(
        .SYNC_STAGES (2),
        .CNT_W       (32),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .tone_in (tone_in),
        .bus     (bus_if)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    // generator and model state
    bit   gen_en  = 0;
    int   half_hi = 102;
    int   half_lo = 102;
    int   m_state = 0;   // 0 idle, 1 armed, 2 measure
    int   m_prev  = 0;
    int   rd_mode = 1;   // 0 none, 1 auto-read, 2 hold rd_re high

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int d, input bit s);
        exp_t e;
        e.d = 32'(d);
        e.s = s;
        q.push_back(e);
    endtask

    // Reference behaviour for one pin edge after an interval of h cycles.
    task automatic model_edge(input int h);
        int d;
        int hv;
        if (m_state != 0 && h > TIMEOUT + 1) begin
            if (m_state == 2) push_exp(0, 1'b1);
            m_state = 0;
            m_prev  = 0;
        end
        if (m_state == 0) begin
            m_state = 1;
        end else begin
            hv = h;
`ifdef TONE_METER_AVG_EN
            if (m_state == 2) hv = (h + m_prev) / 2;
`endif
            d = (hv < 2) ? 0 : hv - 2;
            push_exp(d, 1'b0);
            m_prev  = h;
            m_state = 2;
        end
    endtask

    // Tone generator: toggles the pin after half_hi / half_lo cycles.
    initial begin
        int gap;
        tone_in = 1'b1;
        gap = 0;
        forever begin
            @(negedge clk);
            if (!gen_en) begin
                gap = 0;
            end else begin
                gap++;
                if (gap >= (tone_in ? half_hi : half_lo)) begin
                    tone_in = ~tone_in;
                    model_edge(gap);
                    gap = 0;
                end
            end
        end
    end

    // Reader: drives rd_re according to rd_mode, mid-cycle.
    initial begin
        bus_if.rd_re = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            case (rd_mode)
                1:       bus_if.rd_re = bus_if.rd_valid;
                2:       bus_if.rd_re = 1'b1;
                default: bus_if.rd_re = 1'b0;
            endcase
        end
    end

    // Monitor: each new sample is compared against the scoreboard head.
    initial begin
        logic vp;
        exp_t e;
        vp = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.rd_valid && !vp) begin
                total++;
                assert (q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_sample observed rd_do=%0d silent=%0b expected=no sample",
                           bus_if.rd_do, bus_if.silent);
                end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    $display("sample rd_do=%0d silent=%0b exp_do=%0d exp_silent=%0b",
                             bus_if.rd_do, bus_if.silent, e.d, e.s);
                    chk("sample_do", bus_if.rd_do, e.d);
                    chk("sample_silent", 32'(bus_if.silent), 32'(e.s));
                end
            end
            vp = bus_if.rd_valid;
        end
    end

    task automatic wait_rise(input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(negedge clk);
            if (bus_if.rd_valid) found = 1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        resetn = 1'b0;

        // reset with pin high
        repeat (3) @(negedge clk);
        chk("rst_do", bus_if.rd_do, 0);
        chk("rst_valid", 32'(bus_if.rd_valid), 0);
        chk("rst_silent", 32'(bus_if.silent), 1);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("spurious_edge_no_sample", 32'(bus_if.rd_valid), 0);
        chk("spurious_edge_silent", 32'(bus_if.silent), 1);
        // armed timeout stays quiet
        repeat (1100) @(negedge clk);
        chk("armed_to_valid", 32'(bus_if.rd_valid), 0);
        chk("armed_to_do", bus_if.rd_do, 0);

        // divider 100
        @(posedge clk) gen_en = 1;
        repeat (700) @(negedge clk);
        chk("div100_silent", 32'(bus_if.silent), 0);
        chk("div100_do", bus_if.rd_do, 100);

        // lone read pulse
        rd_mode = 0;
        wait_rise("manual_wait");
        repeat (2) @(negedge clk);
        chk("valid_held", 32'(bus_if.rd_valid), 1);
        rd_mode = 1;
        @(negedge clk);
        rd_mode = 0;
        chk("read_clears_valid", 32'(bus_if.rd_valid), 0);
        chk("read_keeps_do", bus_if.rd_do, 100);
        repeat (3) @(negedge clk);
        chk("idle_read_no_effect", bus_if.rd_do, 100);

        // rd_re held across samples: sample still wins
        rd_mode = 2;
        wait_rise("hold_wait1");
        @(negedge clk);
        chk("hold_clears", 32'(bus_if.rd_valid), 0);
        wait_rise("hold_wait2");
        chk("hold_sample_do", bus_if.rd_do, 100);
        rd_mode = 1;

        // divider change to 37
        @(posedge clk) begin half_hi = 39; half_lo = 39; end
        repeat (500) @(negedge clk);
        chk("div37_do", bus_if.rd_do, 37);

        // asymmetric duty 60/140
        @(posedge clk) begin half_hi = 60; half_lo = 140; end
        repeat (1000) @(negedge clk);

        // interval ending exactly at timeout is still valid
        @(posedge clk) begin half_hi = 1001; half_lo = 1001; end
        repeat (3500) @(negedge clk);
        chk("edge_at_timeout_do", bus_if.rd_do, 999);
        chk("edge_at_timeout_silent", 32'(bus_if.silent), 0);

        // silence
        @(posedge clk) begin
            gen_en = 0;
            if (m_state == 2) push_exp(0, 1'b1);
            m_state = 0;
            m_prev  = 0;
        end
        repeat (1100) @(negedge clk);
        chk("silence_flag", 32'(bus_if.silent), 1);
        chk("silence_do", bus_if.rd_do, 0);
        repeat (1100) @(negedge clk);
        chk("silence_once", 32'(q.size()), 0);

        // reset mid-interval
        @(posedge clk) begin half_hi = 50; half_lo = 50; gen_en = 1; end
        repeat (300) @(negedge clk);
        @(posedge clk) gen_en = 0;
        repeat (10) @(negedge clk);
        chk("pre_reset_drained", 32'(q.size()), 0);
        resetn = 1'b0;
        #1;
        chk("midrst_do", bus_if.rd_do, 0);
        chk("midrst_valid", 32'(bus_if.rd_valid), 0);
        chk("midrst_silent", 32'(bus_if.silent), 1);
        m_state = 0;
        m_prev  = 0;
        q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (1100) @(negedge clk);
        chk("post_rst_valid", 32'(bus_if.rd_valid), 0);
        @(posedge clk) gen_en = 1;
        repeat (300) @(negedge clk);
        @(posedge clk) gen_en = 0;
        repeat (10) @(negedge clk);
        chk("post_rst_do", bus_if.rd_do, 48);
        chk("post_rst_silent", 32'(bus_if.silent), 0);
        chk("scoreboard_empty", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
